// File: rtl/booth_mcp_controller_pkg.sv
// Shared types and widths for the multicycle Booth multiplier controller.
// Also holds the radix-4 Booth partial-product selector used by the array.
package booth_mcp_controller_pkg;

  localparam int OP_W   = 64;
  localparam int PROD_W = 128;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Radix-4 Booth digit {b[2i+1], b[2i], b[2i-1]} selects 0, +-1x or +-2x.
  function automatic logic [PROD_W-1:0] booth_pp(input logic [2:0] sel,
                                                 input logic [PROD_W-1:0] a_ext);
    logic [PROD_W-1:0] pp;
    case (sel)
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = (~a_ext + 1'b1) << 1;
      3'b101, 3'b110: pp = ~a_ext + 1'b1;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

endpackage

// File: rtl/booth_multiplier.sv
// Combinational signed 64x64 radix-4 Booth array producing a full 128-bit product.
// Deep logic: the controller gives it several cycles to settle before sampling.
module booth_multiplier
  import booth_mcp_controller_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  localparam int NDIG = OP_W / 2;

  logic [PROD_W-1:0] a_ext;
  logic [OP_W:0]     b_ext;
  logic [PROD_W-1:0] pp [NDIG];

  assign a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
  assign b_ext = {b, 1'b0};

  for (genvar g = 0; g < NDIG; g++) begin : g_pp
    assign pp[g] = booth_pp(b_ext[2*g+2 : 2*g], a_ext) << (2*g);
  end

  always_comb begin
    p = '0;
    for (int i = 0; i < NDIG; i++) begin
      p = p + pp[i[4:0]];
    end
  end

endmodule

// File: rtl/booth_mcp_controller.sv
// Multicycle controller around a combinational Booth multiplier: registers the
// operands, waits SETTLE_CYCLES edges, then captures the product for handoff.
module booth_mcp_controller
  import booth_mcp_controller_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   multiplier,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic [31:0]       op_count,
  output logic [1:0]        fsm_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [PROD_W-1:0] array_out;
  logic              accept;
  logic              handoff;

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  // Ready never depends on valid of the same side; flush cancels any accept.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign handoff   = out_valid && out_ready;
  assign fsm_state = state;

  // op_a/op_b -> product is a multicycle path of SETTLE_CYCLES in timing constraints.
  booth_multiplier u_mult (
    .a (op_a),
    .b (op_b),
    .p (array_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= multiplicand;
            op_b  <= multiplier;
            cnt   <= CNT_LOAD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            product   <= array_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (handoff) begin
            op_count  <= op_count + 32'd1;
            out_valid <= 1'b0;
            if (accept) begin
              op_a  <= multiplicand;
              op_b  <= multiplier;
              cnt   <= CNT_LOAD;
              state <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mcp_controller.sv
// Scoreboard bench for booth_mcp_controller: driver pushes expected products on
// accept, a negedge monitor pops and compares on every handoff.
module tb_booth_mcp_controller;
  import booth_mcp_controller_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  multiplier;
  logic [63:0]  multiplicand;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] product;
  logic [31:0]  op_count;
  logic [1:0]   fsm_state;

  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_rise = 0;
  logic         prev_ov = 1'b0;

  booth_mcp_controller #(.SETTLE_CYCLES(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .op_count     (op_count),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    return sa * sb;
  endfunction

  // driver tasks
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [127:0] exp, input bit keep);
    bit rdy;
    bit done;
    done         = 1'b0;
    in_valid     = 1'b1;
    multiplier   = a;
    multiplicand = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rdy = in_ready && !flush;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
    end
    #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    chk("drain", 128'(ok), 128'd1);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (flush) begin
          exp_q.delete();
          lat_q.delete();
        end else if (in_valid && in_ready) begin
          lat_q.push_back(cyc + 1);
        end
        if (out_valid && !prev_ov) begin
          if (lat_q.size() == 0) begin
            chk("unexpected_out_valid", 128'd1, 128'd0);
          end else begin
            chk("latency", 128'(cyc - lat_q.pop_front()), 128'(N));
          end
          last_rise = cyc;
        end
        if (out_valid && out_ready && !flush) begin
          if (exp_q.size() == 0) chk("unexpected_handoff", 128'd1, 128'd0);
          else chk("product", product, exp_q.pop_front());
        end
        prev_ov = out_valid;
      end else begin
        prev_ov = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0]  ra;
    logic [63:0]  rb;
    logic [127:0] last_exp;
    int           bb_start;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    multiplier   = '0;
    multiplicand = '0;
    flush        = 1'b0;
    out_ready    = 1'b1;
    last_exp     = '0;
    bb_start     = 0;

    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_product", product, 128'd0);
    chk("rst_op_count", 128'(op_count), 128'd0);
    chk("rst_state", 128'(fsm_state), 128'(IDLE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // 3 x -5 = -15
    send(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, {{124{1'b1}}, 4'h1}, 1'b0);
    drain();
    chk("count_after_first", 128'(op_count), 128'd1);

    // most negative squared
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
         128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    drain();
    chk("count_after_min", 128'(op_count), 128'd2);

    // back-pressure with a new pair waiting
    out_ready = 1'b0;
    send(64'd7, 64'd9, 128'd63, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    @(posedge clk);
    #1;
    fork
      send(64'hFFFF_FFFF_FFFF_FFFE, 64'd4, {{124{1'b1}}, 4'h8}, 1'b0);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("bp_in_ready", 128'(in_ready), 128'd0);
          chk("bp_product", product, 128'd63);
          chk("bp_hold_valid", 128'(out_valid), 128'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("count_after_bp", 128'(op_count), 128'd4);

    // back-to-back random pairs
    for (int k = 0; k < 100; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      last_exp = ref_mul(ra, rb);
      send(ra, rb, last_exp, 1'b1);
      if (k == 0) bb_start = cyc;
    end
    in_valid = 1'b0;
    drain();
    chk("count_after_bb", 128'(op_count), 128'd104);
    chk("bb_throughput", 128'(last_rise - bb_start), 128'(100 * (N + 1) - 1));

    // flush during the second settle cycle
    send(64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000, 1'b0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_state", 128'(fsm_state), 128'(IDLE));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("flush_no_valid", 128'(out_valid), 128'd0);
    end
    chk("flush_product", product, last_exp);
    chk("flush_count", 128'(op_count), 128'd104);
    @(posedge clk);
    #1;

    // reset mid-settle
    send(64'd5, 64'd5, 128'd25, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_count", 128'(op_count), 128'd0);
    chk("mid_rst_product", product, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_state", 128'(fsm_state), 128'(IDLE));
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 128'(out_valid), 128'd0);
    end
    @(posedge clk);
    #1;

    // op_count wrap
    force dut.op_count = 32'hFFFF_FFFF;
    #1 release dut.op_count;
    chk("preload_count", 128'(op_count), 128'hFFFF_FFFF);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0);
    drain();
    chk("count_wrap", 128'(op_count), 128'd0);

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mcp_controller.md
BOOTH_MCP_CONTROLLER -- requirements
Module: booth_mcp_controller

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: number of clock cycles the registered operands are held before the product is captured; legal range 1..15.
REQ-002 clk  input  1: single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1: reset, asynchronous, active-low.
REQ-004 in_valid  input  1: upstream operand pair is valid.
REQ-005 in_ready  output  1: block accepts an operand pair this cycle.
REQ-006 multiplier  input  64: signed two's-complement operand.
REQ-007 multiplicand  input  64: signed two's-complement operand.
REQ-008 flush  input  1: synchronous abort of any operation in flight.
REQ-009 out_valid  output  1: product register holds a valid result.
REQ-010 out_ready  input  1: downstream consumes the result this cycle.
REQ-011 product  output  128: registered signed product.
REQ-012 op_count  output  32: number of results handed off downstream.

Function
REQ-013 FSM states: IDLE, SETTLE, DONE.
REQ-014 in_ready SHALL be 1 in IDLE, or in DONE when out_ready=1; otherwise 0.
REQ-015 Accept occurs on an edge where in_valid and in_ready are both 1: the edge loads the operand registers, loads the counter with SETTLE_CYCLES-1, and enters SETTLE.
REQ-016 The combinational signed 64x64 Booth array SHALL be driven only from the operand registers, never from the input ports.
REQ-017 SETTLE: at each edge, if the counter is 0, capture the array output into product and enter DONE; otherwise decrement the counter.
REQ-018 Latency: for an accept at edge E0, out_valid SHALL rise after edge E0+SETTLE_CYCLES and not before.
REQ-019 DONE: out_valid=1; product and the operand registers SHALL stay stable until handoff.
REQ-020 Handoff occurs on an edge with out_valid=1 and out_ready=1: op_count increments, modulo 2^32, with wrap from FFFFFFFF to 0.
REQ-021 Handoff without a simultaneous accept: go to IDLE and deassert out_valid.
REQ-022 Handoff with a simultaneous accept: go directly to SETTLE with the new operands; out_valid=0 on the next cycle. No bubble is added beyond the settle time.
REQ-023 flush=1 at any edge SHALL force IDLE, out_valid=0, and counter=0, and SHALL block any accept on that edge.
REQ-024 flush SHALL leave product and op_count unchanged, and a flushed operation SHALL NOT increment op_count.
REQ-025 in_valid while in SETTLE is ignored: no accept and no state change.
REQ-026 The full-range product (-2^63 x -2^63 = 2^126) SHALL be represented exactly; no truncation or saturation.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately set: state=IDLE, out_valid=0, product=0, operand registers=0, counter=0, op_count=0.
REQ-028 in_ready SHALL read 1 while rst_n=0 and after release; the first accept occurs at the first edge after release.
REQ-029 Reset mid-operation SHALL discard the operation in flight, with no result and no op_count change.

Structure
REQ-030 The shared package SHALL hold: the state enum (IDLE/SETTLE/DONE), operand width 64, product width 128, and the counter width (4).
REQ-031 One sub-module: the existing combinational booth_multiplier, instantiated once. The FSM, counter, and registers SHALL live in this module.
REQ-032 The path from the operand registers to product SHALL be declared a multicycle path of SETTLE_CYCLES in constraints.

Verification
REQ-033 SETTLE_CYCLES=4, 3 x -5, out_ready=1 -> out_valid rises exactly 4 edges after accept; product = FFFF...FFF1 (-15); op_count=1.
REQ-034 Operands 8000_0000_0000_0000 x 8000_0000_0000_0000 -> product = 4000_0000_0000_0000_0000_0000_0000_0000.
REQ-035 Back-pressure: out_ready=0 for 10 cycles, in_valid held high with new operands -> product stable, in_ready=0 throughout; after out_ready=1, the next result is correct and op_count=2.
REQ-036 Back-to-back: in_valid and out_ready held high, 100 random pairs -> one result every SETTLE_CYCLES+1 cycles, all matching the reference model, op_count=100.
REQ-037 flush in the 2nd SETTLE cycle, then rst_n pulsed low mid-SETTLE of a later operation -> no out_valid for either; after reset, state IDLE and op_count=0.
REQ-038 op_count preloaded by forcing to FFFF_FFFF, then one handoff -> op_count=0.
